// File: rtl/systolic_feeder_if.sv
// Load port, start control and skewed X/W feed bus of the systolic feeder.
interface systolic_feeder_if #(
  parameter int unsigned M          = 5,
  parameter int unsigned N          = 3,
  parameter int unsigned K          = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                    ld_valid;
  logic                    ld_sel;
  logic [ADDR_WIDTH-1:0]   ld_addr;
  logic [DATA_WIDTH-1:0]   ld_data;
  logic                    ld_ready;
  logic                    start;
  logic                    busy;
  logic                    feed_valid;
  logic [DATA_WIDTH*M-1:0] X;
  logic [DATA_WIDTH*K-1:0] W;
  logic                    done;

  // Controller side: loads operands, starts a sequence, observes the feed.
  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, start,
    input  ld_ready, busy, feed_valid, X, W, done
  );

  // Feeder side.
  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, start,
    output ld_ready, busy, feed_valid, X, W, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Stages A (MxN) and B (NxK) and streams them diagonally skewed onto the
// X/W lanes of a systolic MAC array, then zero-flushes and pulses done.
module systolic_feeder #(
  parameter int unsigned M          = 5,
  parameter int unsigned N          = 3,
  parameter int unsigned K          = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);

  localparam int unsigned MN         = M * N;
  localparam int unsigned NK         = N * K;
  localparam int unsigned MAX_MK     = (M > K) ? M : K;
  localparam int unsigned FEED_LAST  = N + MAX_MK - 2;
  localparam int unsigned FLUSH_LAST = N + M + K - 1;
  localparam int unsigned T_W        = $clog2(N + M + K + 1);
  localparam int unsigned A_IW       = (MN > 1) ? $clog2(MN) : 1;
  localparam int unsigned B_IW       = (NK > 1) ? $clog2(NK) : 1;
  localparam int unsigned DW         = DATA_WIDTH;

  localparam logic [ADDR_WIDTH:0] A_LIM = (ADDR_WIDTH+1)'(MN);
  localparam logic [ADDR_WIDTH:0] B_LIM = (ADDR_WIDTH+1)'(NK);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [DW*M-1:0]   x_q, x_d;
  logic [DW*K-1:0]   w_q, w_d;
  logic              busy_q, busy_d;
  logic              fv_q, fv_d;
  logic              done_q, done_d;
  logic              feed_en;
  logic              ld_ready_c;
  logic              ld_fire;
  logic [DW-1:0]     a_q [MN];
  logic [DW-1:0]     b_q [NK];

  assign ld_ready_c     = (state_q == IDLE) && !bus.start;
  assign ld_fire        = bus.ld_valid && ld_ready_c;
  assign bus.ld_ready   = ld_ready_c;
  assign bus.busy       = busy_q;
  assign bus.feed_valid = fv_q;
  assign bus.X          = x_q;
  assign bus.W          = w_q;
  assign bus.done       = done_q;

  // Operand storage; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MN); i++) a_q[i] <= '0;
      for (int i = 0; i < int'(NK); i++) b_q[i] <= '0;
    end else if (ld_fire) begin
      if (!bus.ld_sel && ({1'b0, bus.ld_addr} < A_LIM)) begin
        a_q[A_IW'(bus.ld_addr)] <= bus.ld_data;
      end else if (bus.ld_sel && ({1'b0, bus.ld_addr} < B_LIM)) begin
        b_q[B_IW'(bus.ld_addr)] <= bus.ld_data;
      end
    end
  end

  // Sequencer state, step counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      x_q     <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      x_q     <= x_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
    end
  end

  // Next state and the skewed lane data for the step being registered.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    busy_d  = 1'b0;
    fv_d    = 1'b0;
    done_d  = 1'b0;
    feed_en = 1'b0;
    x_d     = '0;
    w_d     = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FEED;
          t_d     = '0;
          busy_d  = 1'b1;
          fv_d    = 1'b1;
          feed_en = 1'b1;
        end
      end
      FEED: begin
        t_d    = t_q + T_W'(1);
        busy_d = 1'b1;
        if (t_q == T_W'(FEED_LAST)) begin
          state_d = FLUSH;
        end else begin
          fv_d    = 1'b1;
          feed_en = 1'b1;
        end
      end
      FLUSH: begin
        if (t_q == T_W'(FLUSH_LAST)) begin
          state_d = IDLE;
          t_d     = '0;
          done_d  = 1'b1;
        end else begin
          t_d    = t_q + T_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (feed_en) begin
      for (int i = 0; i < int'(M); i++) begin
        automatic int d = int'(t_d) - i;
        if (d >= 0 && d < int'(N)) x_d[DW*i +: DW] = a_q[A_IW'(i * int'(N) + d)];
      end
      for (int j = 0; j < int'(K); j++) begin
        automatic int d = int'(t_d) - j;
        if (d >= 0 && d < int'(N)) w_d[DW*j +: DW] = b_q[B_IW'(d * int'(K) + j)];
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: per-cycle compare against a
// cycle-offset model plus hand-computed lane and timing expectations.
module tb_systolic_feeder;

  localparam int unsigned M  = 5;
  localparam int unsigned N  = 3;
  localparam int unsigned K  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int FEED_LEN    = N + ((M > K) ? M : K) - 1;
  localparam int DONE_C      = N + M + K;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_feeder_if #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  systolic_feeder #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mc = cycles since the first FEED cycle, -1 when idle.
  int          mc = -1;
  logic [DW-1:0] ma [M][N];
  logic [DW-1:0] mb [N][K];
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW*M-1:0] exp_x(input int c);
    logic [DW*M-1:0] r = '0;
    for (int i = 0; i < int'(M); i++)
      if (c >= 0 && c < FEED_LEN && c - i >= 0 && c - i < int'(N)) r[DW*i +: DW] = ma[i][c-i];
    return r;
  endfunction

  function automatic logic [DW*K-1:0] exp_w(input int c);
    logic [DW*K-1:0] r = '0;
    for (int j = 0; j < int'(K); j++)
      if (c >= 0 && c < FEED_LEN && c - j >= 0 && c - j < int'(N)) r[DW*j +: DW] = mb[c-j][j];
    return r;
  endfunction

  // Model update at each rising edge from the stable inputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      mc = -1;
      for (int i = 0; i < int'(M); i++) for (int n = 0; n < int'(N); n++) ma[i][n] = '0;
      for (int n = 0; n < int'(N); n++) for (int j = 0; j < int'(K); j++) mb[n][j] = '0;
    end else if (mc < 0 || mc == DONE_C) begin
      if (bus.start) mc = 0;
      else begin
        mc = -1;
        if (bus.ld_valid) begin
          automatic int a = int'(bus.ld_addr);
          if (!bus.ld_sel && a < int'(M*N)) ma[a/N][a%N] = bus.ld_data;
          else if (bus.ld_sel && a < int'(N*K)) mb[a/K][a%K] = bus.ld_data;
        end
      end
    end else begin
      mc++;
    end
    chk_en = 1'b1;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit idle = (mc < 0) || (mc == DONE_C);
      check("busy",       256'(bus.busy),       256'(mc >= 0 && mc < DONE_C));
      check("feed_valid", 256'(bus.feed_valid), 256'(mc >= 0 && mc < FEED_LEN));
      check("done",       256'(bus.done),       256'(mc == DONE_C));
      check("ld_ready",   256'(bus.ld_ready),   256'(idle && !bus.start));
      check("X",          256'(bus.X),          256'(exp_x(mc)));
      check("W",          256'(bus.W),          256'(exp_w(mc)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = AW'(addr);
    bus.ld_data  = DW'(data);
    tick();
    bus.ld_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] xl(input int i);
    return bus.X[DW*i +: DW];
  endfunction

  function automatic logic [DW-1:0] wl(input int j);
    return bus.W[DW*j +: DW];
  endfunction

  int fv_cnt, bz_cnt, dn_cnt, dn_k;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_sel   = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ld_ready", 256'(bus.ld_ready), 256'(1));
    check("rst_X",        256'(bus.X),        256'(0));
    tick();

    // Operands A[i][n]=10i+n+1, B[n][j]=100n+j+1, then out-of-range writes.
    for (int i = 0; i < int'(M); i++)
      for (int n = 0; n < int'(N); n++) wr(1'b0, i*N + n, 10*i + n + 1);
    for (int n = 0; n < int'(N); n++)
      for (int j = 0; j < int'(K); j++) wr(1'b1, n*K + j, 100*n + j + 1);
    wr(1'b0, 15, 'hDEAD);
    wr(1'b0, 17, 'hDEAD);
    wr(1'b1, 12, 'hBEEF);
    wr(1'b1, 18, 'hBEEF);

    // Sequence 1: skew and timing, with loads attempted while busy.
    bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_sel   = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = DW'(999);
    fv_cnt = 0; bz_cnt = 0; dn_cnt = 0; dn_k = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("s0_x0", 256'(xl(0)), 256'(1));
        check("s0_x1", 256'(xl(1)), 256'(0));
        check("s0_w0", 256'(wl(0)), 256'(1));
        check("s0_w1", 256'(wl(1)), 256'(0));
      end
      if (k == 2) begin
        check("s2_x0", 256'(xl(0)), 256'(3));
        check("s2_x1", 256'(xl(1)), 256'(12));
        check("s2_x2", 256'(xl(2)), 256'(21));
        check("s2_x3", 256'(xl(3)), 256'(0));
        check("s2_w0", 256'(wl(0)), 256'(201));
        check("s2_w1", 256'(wl(1)), 256'(102));
        check("s2_w2", 256'(wl(2)), 256'(3));
        check("s2_w3", 256'(wl(3)), 256'(0));
      end
      if (k == 6) begin
        check("s6_x4", 256'(xl(4)), 256'(43));
        check("s6_x3", 256'(xl(3)), 256'(0));
        check("s6_W",  256'(bus.W), 256'(0));
      end
      if (bus.feed_valid) fv_cnt++;
      if (bus.busy) bz_cnt++;
      if (bus.done) begin dn_cnt++; dn_k = k; end
      tick();
      if (k == 3) bus.ld_valid = 1'b0;
    end
    check("feed_cycles", 256'(fv_cnt), 256'(7));
    check("busy_cycles", 256'(bz_cnt), 256'(12));
    check("done_count",  256'(dn_cnt), 256'(1));
    check("done_cycle",  256'(dn_k),   256'(12));

    // Sequence 2: start and load in the same idle cycle; start wins.
    bus.start    = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_sel   = 1'b0;
    bus.ld_addr  = AW'(1);
    bus.ld_data  = DW'(777);
    tick();
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_wr_ignored", 256'(xl(0)), 256'(1));
      if (k == 1) check("start_wins_x0", 256'(xl(0)), 256'(2));
      tick();
    end

    // Sequence 3: start held high, back-to-back runs.
    bus.start = 1'b1;
    tick();
    dn_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done) dn_cnt++;
      if (k == 12) check("b2b_fv_at_done", 256'(bus.feed_valid), 256'(0));
      if (k == 13) begin
        check("b2b_fv_after", 256'(bus.feed_valid), 256'(1));
        check("b2b_s0_x0",    256'(xl(0)),          256'(1));
      end
      if (k == 15) check("b2b_s2_w0", 256'(wl(0)), 256'(201));
      tick();
    end
    check("b2b_done_count", 256'(dn_cnt), 256'(2));
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) tick();

    // Sequence 4: reset mid-FEED clears state and operands.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",     256'(bus.busy),     256'(0));
    check("mid_rst_done",     256'(bus.done),     256'(0));
    check("mid_rst_ld_ready", 256'(bus.ld_ready), 256'(1));
    check("mid_rst_W",        256'(bus.W),        256'(0));
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dn_k = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) check("replay_fv", 256'(bus.feed_valid), 256'(1));
      if (k == 2) check("replay_zero_X", 256'(bus.X), 256'(0));
      if (bus.done) dn_k = k;
      tick();
    end
    check("replay_done_cycle", 256'(dn_k), 256'(12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
